airlock_chamber_model: RTL



---
 rtl/airlock_pkg.sv | 24 ++
 rtl/airlock_door.sv | 60 ++++++
 rtl/airlock_chamber_model.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/airlock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : airlock_pkg
// Purpose  : Shared definitions for the airlock chamber plant model:
//            pressure state encodings and default plant timing values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package airlock_pkg;

    // Pressure FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_DEPR       = 2'd0,   // stable vacuum
        ST_PRESSING   = 2'd1,   // pumping in
        ST_PRESS      = 2'd2,   // stable full pressure
        ST_DEPRESSING = 2'd3    // pumping out
    } state_e;

    // Default plant timing
    localparam int unsigned LEVEL_MAX_DEF   = 7;
    localparam int unsigned DOOR_CYCLES_DEF = 2;

endpackage : airlock_pkg
`default_nettype wire

// File: rtl/airlock_door.sv
`default_nettype none
// ============================================================================
// Module   : airlock_door
// Purpose  : One airlock door: an opening counter plus a registered open flag.
//            The counter advances while the request is held and the door is
//            permitted; otherwise it returns to zero on the next edge.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req_i      - door open request (level)
//            permit_i   - interlock permits this door to move
//            open_o     - door fully open (registered)
//            active_o   - opening counter is non-zero
//            viol_o     - request while not permitted (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module airlock_door
    import airlock_pkg::*;
#(
    parameter int unsigned DOOR_CYCLES = DOOR_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic permit_i,
    output logic open_o,
    output logic active_o,
    output logic viol_o
);

    localparam int unsigned      CNT_W    = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_OPEN = CNT_W'(DOOR_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             open_q;

    // Counter holds at CNT_OPEN so a held request keeps the door open.
    always_comb begin
        cnt_d = '0;
        if (req_i && permit_i) begin
            cnt_d = (cnt_q == CNT_OPEN) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            open_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            open_q <= (cnt_d == CNT_OPEN);
        end
    end

    assign open_o   = open_q;
    assign active_o = (cnt_q != '0);
    assign viol_o   = req_i && !permit_i;

endmodule : airlock_door
`default_nettype wire

// File: rtl/airlock_chamber_model.sv
`default_nettype none
// ============================================================================
// Module   : airlock_chamber_model
// Purpose  : Behavioural plant model of an airlock chamber. Models pressure as
//            a saturating level counter driven by pump commands, two doors
//            with opening delays, and a sticky interlock-violation flag.
// Ports    : clk                - clock, rising edge
//            rst_n              - asynchronous active-low reset
//            pump_in_i          - pressurize command
//            pump_out_i         - depressurize command
//            inner_open_req_i   - hold inner (ship-side) door open
//            outer_open_req_i   - hold outer (space-side) door open
//            pressurized_o      - chamber stable at full pressure
//            depressurized_o    - chamber stable at vacuum
//            busy_o             - pumping in either direction
//            inner_open_o       - inner door fully open
//            outer_open_o       - outer door fully open
//            violation_o        - sticky interlock violation
//            press_level_o      - current pressure level
// Revision : 1.0 - initial release
// ============================================================================
module airlock_chamber_model
    import airlock_pkg::*;
#(
    parameter int unsigned LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int unsigned DOOR_CYCLES = DOOR_CYCLES_DEF,
    parameter int unsigned LVL_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pump_in_i,
    input  logic             pump_out_i,
    input  logic             inner_open_req_i,
    input  logic             outer_open_req_i,
    output logic             pressurized_o,
    output logic             depressurized_o,
    output logic             busy_o,
    output logic             inner_open_o,
    output logic             outer_open_o,
    output logic             violation_o,
    output logic [LVL_W-1:0] press_level_o
);

    localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(LEVEL_MAX);
    localparam logic [LVL_W-1:0] LVL_FULL_M1  = LVL_W'(LEVEL_MAX - 1);
    localparam logic [LVL_W-1:0] LVL_ONE      = LVL_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             press_q;
    logic             depr_q;
    logic             busy_q;
    logic             viol_q;
    logic             viol_d;

    logic inner_active;
    logic outer_active;
    logic inner_viol;
    logic outer_viol;
    logic inner_open;
    logic outer_open;

    // Interlock qualification of the raw commands
    logic both_doors;
    logic doors_busy;
    logic pump_conflict;
    logic pump_any;
    logic pump_in_ok;
    logic pump_out_ok;
    logic inner_req_eff;
    logic outer_req_eff;
    logic inner_permit;
    logic outer_permit;

    assign both_doors    = inner_open_req_i && outer_open_req_i;
    assign doors_busy    = inner_active || outer_active;
    assign pump_conflict = pump_in_i && pump_out_i;
    assign pump_any      = pump_in_i || pump_out_i;
    // Pumping is blocked outright while either door has started to move.
    assign pump_in_ok    = pump_in_i  && !pump_out_i && !doors_busy;
    assign pump_out_ok   = pump_out_i && !pump_in_i  && !doors_busy;
    // Simultaneous door requests are both dropped before reaching the doors.
    assign inner_req_eff = inner_open_req_i && !both_doors;
    assign outer_req_eff = outer_open_req_i && !both_doors;
    assign inner_permit  = (state_q == ST_PRESS) && !outer_active;
    assign outer_permit  = (state_q == ST_DEPR)  && !inner_active;

    airlock_door #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_inner_door (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (inner_req_eff),
        .permit_i (inner_permit),
        .open_o   (inner_open),
        .active_o (inner_active),
        .viol_o   (inner_viol)
    );

    airlock_door #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_outer_door (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (outer_req_eff),
        .permit_i (outer_permit),
        .open_o   (outer_open),
        .active_o (outer_active),
        .viol_o   (outer_viol)
    );

    // Pressure next-state. A reversal holds the level for one edge; reaching
    // the end stop (including from an already-saturated level) settles.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            ST_DEPR: begin
                if (pump_in_ok) state_d = ST_PRESSING;
            end
            ST_PRESSING: begin
                if (pump_out_ok) begin
                    state_d = ST_DEPRESSING;
                end else if (level_q >= LVL_FULL_M1) begin
                    level_d = LVL_FULL;
                    state_d = ST_PRESS;
                end else begin
                    level_d = level_q + 1'b1;
                end
            end
            ST_PRESS: begin
                if (pump_out_ok) state_d = ST_DEPRESSING;
            end
            ST_DEPRESSING: begin
                if (pump_in_ok) begin
                    state_d = ST_PRESSING;
                end else if (level_q <= LVL_ONE) begin
                    level_d = '0;
                    state_d = ST_DEPR;
                end else begin
                    level_d = level_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_PRESS;
                level_d = LVL_FULL;
            end
        endcase
    end

    assign viol_d = viol_q || inner_viol || outer_viol || both_doors ||
                    (pump_any && doors_busy) || pump_conflict;

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PRESS;
            level_q <= LVL_FULL;
            press_q <= 1'b1;
            depr_q  <= 1'b0;
            busy_q  <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            press_q <= (state_d == ST_PRESS);
            depr_q  <= (state_d == ST_DEPR);
            busy_q  <= (state_d == ST_PRESSING) || (state_d == ST_DEPRESSING);
            viol_q  <= viol_d;
        end
    end

    assign pressurized_o   = press_q;
    assign depressurized_o = depr_q;
    assign busy_o          = busy_q;
    assign inner_open_o    = inner_open;
    assign outer_open_o    = outer_open;
    assign violation_o     = viol_q;
    assign press_level_o   = level_q;

endmodule : airlock_chamber_model
`default_nettype wire
